// File: rtl/matrix_pkg.sv
// Shared helpers for the LED matrix scan driver.
//   row_onehot : one-hot row select for a given row index
//   apply_pol  : map an active-high vector onto the pin polarity
// Vectors are carried at MaxWidth bits, so ROWS and COLS must not exceed MaxWidth.
// Callers truncate the result to the width they need.
package matrix_pkg;

    localparam int unsigned MaxWidth = 64;

    typedef logic [MaxWidth-1:0] vec_t;

    // Indices at or beyond MaxWidth shift the bit out, so the result is all zeros.
    function automatic vec_t row_onehot(input int unsigned idx);
        return vec_t'(1) << idx;
    endfunction

    function automatic vec_t apply_pol(input vec_t v, input logic active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/matrix_fb.sv
// Double-buffered frame store for the matrix scan driver.
// Holds two banks of ROWS x COLS bits. Writes always go to the back bank and
// reads always come from the front bank. swap_i exchanges the roles of the banks.
// Nothing is copied on a swap, so the new back bank keeps its old contents.
// Ports:
//   clk_i, rst_ni : clock and asynchronous active-low reset (clears both banks)
//   wr_en_i       : write wr_data_i into back-bank row wr_row_i (out-of-range rows are ignored)
//   swap_i        : exchange the front and back banks on this edge
//   rd_row_i      : front-bank row to read
//   rd_data_o     : combinational read data
module matrix_fb
    import matrix_pkg::*;
#(
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     wr_en_i,
    input  logic [$clog2(ROWS)-1:0]  wr_row_i,
    input  logic [COLS-1:0]          wr_data_i,
    input  logic                     swap_i,
    input  logic [$clog2(ROWS)-1:0]  rd_row_i,
    output logic [COLS-1:0]          rd_data_o
);

    localparam int unsigned RowW = $clog2(ROWS);
    localparam logic [RowW:0] RowsCnt = (RowW + 1)'(ROWS);

    logic [COLS-1:0] bank_q [2][ROWS];
    logic            front_q;
    logic            wr_ok;

    assign wr_ok = {1'b0, wr_row_i} < RowsCnt;

    // A write during the swap cycle goes to the bank that was back before the
    // edge, so it becomes visible right away in the new front bank.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            front_q <= 1'b0;
            for (int r = 0; r < int'(ROWS); r++) begin
                bank_q[0][r] <= '0;
                bank_q[1][r] <= '0;
            end
        end else begin
            if (wr_en_i && wr_ok) begin
                bank_q[~front_q][wr_row_i] <= wr_data_i;
            end
            if (swap_i) begin
                front_q <= ~front_q;
            end
        end
    end

    assign rd_data_o = bank_q[front_q][rd_row_i];

endmodule

// File: rtl/matrix_scan.sv
// LED dot-matrix scan driver.
// Scans one row per slot of DIV cycles. The first BLANK cycles of each slot are
// dark, which stops ghosting between rows. Applies global PWM brightness and the
// configured pin polarity, and exchanges frame buffers only at frame boundaries.
// Ports:
//   clkI, rstN            : clock and asynchronous active-low reset
//   enable                : 0 forces the outputs inactive; the counters keep running
//   wr_en/wr_row/wr_data  : back-buffer row write
//   swap                  : request a buffer exchange at the end of the frame
//   brightness            : global duty; all-ones means full on, 0 means dark
//   swap_done             : one-cycle pulse after the exchange
//   frame_start           : one-cycle pulse for row 0, tick 0
//   matrix_row/matrix_col : registered row select and column drive
module matrix_scan
    import matrix_pkg::*;
#(
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 8,
    parameter int unsigned DIV            = 1000,
    parameter int unsigned BLANK          = 2,
    parameter int unsigned PWM_BITS       = 3,
    parameter bit          ROW_ACTIVE_LOW = 1'b1,
    parameter bit          COL_ACTIVE_LOW = 1'b1
) (
    input  logic                     clkI,
    input  logic                     rstN,
    input  logic                     enable,
    input  logic                     wr_en,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [COLS-1:0]          wr_data,
    input  logic                     swap,
    input  logic [PWM_BITS-1:0]      brightness,
    output logic                     swap_done,
    output logic                     frame_start,
    output logic [ROWS-1:0]          matrix_row,
    output logic [COLS-1:0]          matrix_col
);

    localparam int unsigned RowW  = $clog2(ROWS);
    localparam int unsigned TickW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [TickW-1:0] TickLast  = TickW'(DIV - 1);
    localparam logic [TickW-1:0] TickBlank = TickW'(BLANK);
    localparam logic [RowW-1:0]  RowLast   = RowW'(ROWS - 1);
    localparam logic [ROWS-1:0]  RowIdle   = {ROWS{ROW_ACTIVE_LOW}};
    localparam logic [COLS-1:0]  ColIdle   = {COLS{COL_ACTIVE_LOW}};

    logic [TickW-1:0]    tick_q, tick_d;
    logic [RowW-1:0]     row_q, row_d;
    logic [PWM_BITS-1:0] pwm_q, pwm_d;
    logic                pending_q, pending_d;
    logic                swap_done_q, swap_done_d;
    logic                frame_start_q, frame_start_d;
    logic [ROWS-1:0]     row_out_q, row_out_d;
    logic [COLS-1:0]     col_out_q, col_out_d;

    logic            tick_wrap;
    logic            frame_last;
    logic            do_swap;
    logic            lit;
    logic [COLS-1:0] front_row;

    matrix_fb #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_fb (
        .clk_i     (clkI),
        .rst_ni    (rstN),
        .wr_en_i   (wr_en),
        .wr_row_i  (wr_row),
        .wr_data_i (wr_data),
        .swap_i    (do_swap),
        .rd_row_i  (row_q),
        .rd_data_o (front_row)
    );

    always_comb begin
        tick_wrap  = (tick_q == TickLast);
        frame_last = tick_wrap && (row_q == RowLast);
        // A request arriving on the last cycle of the frame is still taken in this frame.
        do_swap    = frame_last && (pending_q || swap);

        tick_d = tick_wrap ? '0 : tick_q + 1'b1;
        row_d  = row_q;
        if (tick_wrap) begin
            row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
        end
        pwm_d = pwm_q + 1'b1;

        pending_d     = (pending_q || swap) && !do_swap;
        swap_done_d   = do_swap;
        frame_start_d = (tick_q == '0) && (row_q == '0);

        // The row only changes at the tick wrap, which always falls inside blanking.
        lit = enable && (tick_q >= TickBlank)
              && ((brightness == '1) || (pwm_q < brightness));

        row_out_d = ROWS'(apply_pol(lit ? row_onehot(32'(row_q)) : '0, ROW_ACTIVE_LOW));
        col_out_d = COLS'(apply_pol(lit ? MaxWidth'(front_row) : '0, COL_ACTIVE_LOW));
    end

    always_ff @(posedge clkI or negedge rstN) begin
        if (!rstN) begin
            tick_q        <= '0;
            row_q         <= '0;
            pwm_q         <= '0;
            pending_q     <= 1'b0;
            swap_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
            row_out_q     <= RowIdle;
            col_out_q     <= ColIdle;
        end else begin
            tick_q        <= tick_d;
            row_q         <= row_d;
            pwm_q         <= pwm_d;
            pending_q     <= pending_d;
            swap_done_q   <= swap_done_d;
            frame_start_q <= frame_start_d;
            row_out_q     <= row_out_d;
            col_out_q     <= col_out_d;
        end
    end

    assign swap_done   = swap_done_q;
    assign frame_start = frame_start_q;
    assign matrix_row  = row_out_q;
    assign matrix_col  = col_out_q;

endmodule
